mmio_uart_tx: RTL and testbench

- Memory-mapped responder on the core's data-memory port.
- Sits beside `data_mem` and uses the same address, write-data, write-enable and read-data signals.
- When the core stores a byte to the TX register, the block queues it in a small FIFO and serialises it as 8N1 UART frames on `tx`.
- The top level selects this block's `RD` over `data_mem`'s `RD` whenever `hit` is high.

---
 rtl/mmio_uart_pkg.sv | 22 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 59 +++++
 rtl/mmio_uart_tx.sv | 206 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state encoding.
package mmio_uart_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    localparam int unsigned BUSY  = 0;
    localparam int unsigned FULL  = 1;
    localparam int unsigned EMPTY = 2;
    localparam int unsigned OVF   = 3;
    localparam int unsigned IE    = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = din;
            wr_d = wr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO on the core data port.
// Optional interrupt output and STATUS.ie bit when MMIO_UART_IRQ_EN is defined.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        hit,
    output logic        tx
`ifdef MMIO_UART_IRQ_EN
    ,
    output logic        irq
`endif
);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [15:0] div_q, div_d;
    logic [15:0] baud_q, baud_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
    logic        ie_q, ie_d;

    logic [1:0]  off;
    logic        wr_txdata, wr_status, wr_baud;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic        busy, bit_end, load;
    logic [31:0] status;
    logic        unused_bits;

    assign unused_bits = ^{A[1:0], WD[31:16], WD[4]};

    assign hit       = (A[31:4] == BASE_ADDR[31:4]);
    assign off       = A[3:2];
    assign wr_txdata = WE && hit && (off == OFF_TXDATA);
    assign wr_status = WE && hit && (off == OFF_STATUS);
    assign wr_baud   = WE && hit && (off == OFF_BAUD);
    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (wr_txdata),
        .din   (WD[7:0]),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    always_comb begin
        status         = '0;
        status[BUSY]   = busy;
        status[FULL]   = fifo_full;
        status[EMPTY]  = fifo_empty;
        status[OVF]    = ovf_q;
        status[IE]     = ie_q;
        RD = '0;
        if (hit) begin
            case (off)
                OFF_STATUS: RD = status;
                OFF_BAUD:   RD = {16'd0, baud_q};
                default:    RD = '0;
            endcase
        end
    end

    always_comb begin
        baud_d = baud_q;
        ovf_d  = ovf_q;
        ie_d   = ie_q;
        if (wr_baud) begin
            baud_d = (WD[15:0] == 16'd0) ? 16'd1 : WD[15:0];
        end
        if (wr_status && WD[OVF]) begin
            ovf_d = 1'b0;
        end else if (wr_txdata && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
`ifdef MMIO_UART_IRQ_EN
        if (wr_status) begin
            ie_d = WD[IE];
        end
`endif
    end

    // Each bit lasts div_q clocks; a frame ending with data queued reloads
    // straight into START so consecutive frames have no idle gap.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        bit_end    = (baud_cnt_q == div_q - 16'd1);

        case (state_q)
            IDLE: begin
                load = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_d    = DATA;
                    baud_cnt_d = '0;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    load       = !fifo_empty;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_dout;
            div_d      = baud_q;
            bit_cnt_d  = '0;
            baud_cnt_d = '0;
            state_d    = START;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            div_q      <= DIV_RESET;
            baud_q     <= DIV_RESET;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
            ie_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
            ovf_q      <= ovf_d;
            ie_q       <= ie_d;
        end
    end

`ifdef MMIO_UART_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = ie_q && fifo_empty && !busy;
    assign irq   = irq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register-access vector table plus hand-written
// serial timing sequences, with a UART receiver checking every transmitted frame.
module tb_mmio_uart_tx;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic        hit;
    logic        tx;
`ifdef MMIO_UART_IRQ_EN
    logic        irq;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Receiver expectations: one clocks-per-bit and one byte per expected frame.
    int unsigned mon_div  [$];
    logic [7:0]  mon_byte [$];

    mmio_uart_tx #(
        .BASE_ADDR  (32'h0000_1000),
        .FIFO_DEPTH (4),
        .DIV_RESET  (16'd868)
    ) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .WD  (WD),
        .WE  (WE),
        .RD  (RD),
        .hit (hit),
        .tx  (tx)
`ifdef MMIO_UART_IRQ_EN
        ,
        .irq (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        logic [31:0] exp_rd;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        A  = addr;
        WD = data;
        WE = 1'b1;
        @(posedge clk);
    endtask

    task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string name);
        @(negedge clk);
        A  = addr;
        WE = 1'b0;
        #1;
        check(name, RD, exp);
    endtask

    // Waits for busy to rise (if not already high) and counts busy samples.
    task automatic busy_len(output int n);
        int guard;
        n = 0;
        guard = 0;
        @(negedge clk);
        A  = 32'h1004;
        WE = 1'b0;
        #1;
        while (!RD[0] && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        while (RD[0] && guard < 3000) begin
            n++;
            @(negedge clk);
            #1;
            guard++;
        end
        check("busy_drop", {31'd0, RD[0]}, 32'd0);
    endtask

    // UART receiver: samples the first cycle of each bit cell.
    initial begin
        logic [7:0]  mb;
        logic        ms;
        bit          mab;
        int unsigned md;
        logic [7:0]  mexp;
        mb = '0;
        ms = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst && tx == 1'b0) begin
                mab = 1'b0;
                check("rx_frame_expected", {31'd0, (mon_div.size() != 0)}, 32'd1);
                md = (mon_div.size() != 0) ? mon_div.pop_front() : 1;
                for (int i = 0; i < 9; i++) begin
                    repeat (md) @(posedge clk);
                    #1;
                    if (!rst) mab = 1'b1;
                    if (i < 8) mb[i] = tx;
                    else       ms = tx;
                end
                mexp = (mon_byte.size() != 0) ? mon_byte.pop_front() : 8'hxx;
                if (!mab) begin
                    check("rx_byte", {24'd0, mb}, {24'd0, mexp});
                    check("rx_stop", {31'd0, ms}, 32'd1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] frame;
        int         n;

        vecs[0]  = '{"status_reset",   32'h0000_1004, 32'h0,         1'b0, 32'h4,     1'b1};
        vecs[1]  = '{"baud_reset",     32'h0000_1008, 32'h0,         1'b0, 32'd868,   1'b1};
        vecs[2]  = '{"miss_read",      32'h0000_2000, 32'h0,         1'b0, 32'h0,     1'b0};
        vecs[3]  = '{"txdata_read",    32'h0000_1000, 32'h0,         1'b0, 32'h0,     1'b1};
        vecs[4]  = '{"reserved_read",  32'h0000_100C, 32'h0,         1'b0, 32'h0,     1'b1};
        vecs[5]  = '{"baud_write",     32'h0000_1008, 32'h0001_2345, 1'b1, 32'h0,     1'b1};
        vecs[6]  = '{"baud_16bit",     32'h0000_1008, 32'h0,         1'b0, 32'h2345,  1'b1};
        vecs[7]  = '{"reserved_write", 32'h0000_100C, 32'hFFFF_FFFF, 1'b1, 32'h0,     1'b1};
        vecs[8]  = '{"reserved_still", 32'h0000_100C, 32'h0,         1'b0, 32'h0,     1'b1};
        vecs[9]  = '{"miss_write",     32'h0000_2008, 32'h5,         1'b1, 32'h0,     1'b0};
        vecs[10] = '{"baud_low_bits",  32'h0000_100B, 32'h0,         1'b0, 32'h2345,  1'b1};
        vecs[11] = '{"status_write",   32'h0000_1004, 32'hF,         1'b1, 32'h0,     1'b1};
        vecs[12] = '{"status_after",   32'h0000_1004, 32'h0,         1'b0, 32'h4,     1'b1};
        vecs[13] = '{"baud_zero_wr",   32'h0000_1008, 32'h0,         1'b1, 32'h0,     1'b1};
        vecs[14] = '{"baud_zero",      32'h0000_1008, 32'h0,         1'b0, 32'h1,     1'b1};
        vecs[15] = '{"below_window",   32'h0000_0FFC, 32'h0,         1'b0, 32'h0,     1'b0};

        A   = '0;
        WD  = '0;
        WE  = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("tx_after_reset", {31'd0, tx}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            A  = vecs[i].a;
            WD = vecs[i].wd;
            WE = vecs[i].we;
            #1;
            check({vecs[i].name, "_hit"}, {31'd0, hit}, {31'd0, vecs[i].exp_hit});
            if (!vecs[i].we) check(vecs[i].name, RD, vecs[i].exp_rd);
        end

        // 0xA5 at 4 clocks/bit, sampled mid-low-phase once per bit cell.
        wr(32'h1008, 32'd4);
        mon_div.push_back(4);
        mon_byte.push_back(8'hA5);
        wr(32'h1000, 32'hA5);
        @(negedge clk);
        WE = 1'b0;
        A  = 32'h1004;
        #1;
        check("tx_before_pop", {31'd0, tx}, 32'd1);
        frame = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        #1;
        check("a5_bit0", {31'd0, tx}, {31'd0, frame[0]});
        for (int k = 1; k < 10; k++) begin
            repeat (4) @(negedge clk);
            #1;
            check($sformatf("a5_bit%0d", k), {31'd0, tx}, {31'd0, frame[k]});
        end
        repeat (3) @(negedge clk);
        #1;
        check("a5_busy_last", {31'd0, RD[0]}, 32'd1);
        @(negedge clk);
        #1;
        check("a5_done_status", RD, 32'h4);

        // 1 clock per bit: frame is exactly 10 clocks.
        wr(32'h1008, 32'd0);
        mon_div.push_back(1);
        mon_byte.push_back(8'h3C);
        wr(32'h1000, 32'h3C);
        busy_len(n);
        check("div1_frame_len", n, 32'd10);

        // Back-to-back frames at 2 clocks/bit.
        wr(32'h1008, 32'd2);
        mon_div.push_back(2);
        mon_byte.push_back(8'h01);
        mon_div.push_back(2);
        mon_byte.push_back(8'h80);
        wr(32'h1000, 32'h01);
        wr(32'h1000, 32'h80);
        busy_len(n);
        check("b2b_busy_len", n, 32'd40);

        // Overflow: 1st write popped, next 4 fill, 6th dropped.
        wr(32'h1008, 32'd4);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                mon_div.push_back(4);
                mon_byte.push_back(8'(8'h11 * (i + 1)));
            end
            wr(32'h1000, 32'(8'h11 * (i + 1)));
        end
        rd_chk(32'h1004, 32'hB, "ovf_status");
        wr(32'h1004, 32'h8);
        rd_chk(32'h1004, 32'h3, "ovf_cleared");
        // Frames span edges N+1..N+201; counting starts after N+8.
        busy_len(n);
        check("ovf_busy_len", n, 32'd193);

        // BAUDDIV change mid-frame applies only to the following frame.
        wr(32'h1008, 32'd2);
        mon_div.push_back(2);
        mon_byte.push_back(8'hC3);
        mon_div.push_back(8);
        mon_byte.push_back(8'h5A);
        wr(32'h1000, 32'hC3);
        wr(32'h1000, 32'h5A);
        wr(32'h1008, 32'd8);
        // 20 + 80 busy clocks, counting starts one edge into the first frame.
        busy_len(n);
        check("midframe_busy_len", n, 32'd99);
        rd_chk(32'h1008, 32'd8, "midframe_baud");

        // Asynchronous reset in the middle of DATA.
        wr(32'h1008, 32'd4);
        mon_div.push_back(4);
        mon_byte.push_back(8'hF0);
        wr(32'h1000, 32'hF0);
        @(negedge clk);
        WE = 1'b0;
        A  = 32'h1004;
        repeat (7) @(negedge clk);
        #1;
        check("tx_in_data", {31'd0, tx}, 32'd0);
        rst = 1'b0;
        #1;
        check("tx_async_reset", {31'd0, tx}, 32'd1);
        check("status_in_reset", RD, 32'h4);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd_chk(32'h1004, 32'h4, "status_post_reset");
        rd_chk(32'h1008, 32'd868, "baud_post_reset");
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) n++;
        end
        check("tx_quiet_post_reset", n, 32'd0);

`ifdef MMIO_UART_IRQ_EN
        wr(32'h1004, 32'h10);
        rd_chk(32'h1004, 32'h14, "ie_readback");
        check("irq_lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_idle", {31'd0, irq}, 32'd1);
        wr(32'h1008, 32'd1);
        mon_div.push_back(1);
        mon_byte.push_back(8'h55);
        wr(32'h1000, 32'h55);
        @(negedge clk);
        WE = 1'b0;
        @(negedge clk);
        check("irq_busy", {31'd0, irq}, 32'd0);
        repeat (10) @(negedge clk);
        check("irq_stop_end", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, 32'd1);
`endif

        repeat (5) @(negedge clk);
        check("rx_all_frames", mon_byte.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
